tdes_round_ctrl: RTL and testbench

//  Sequencer for the iterative Triple-DES datapath: runs NUM_PASSES DES passes of 16 Feistel

---
 rtl/des_pkg.sv | 47 ++++
 rtl/des_shift_table.sv | 12 +
 rtl/tdes_round_ctrl.sv | 135 +++++++++++++
 tb/tb_tdes_round_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the iterative Triple-DES round sequencer.
// Holds the state encoding, round count, key indices and C/D rotate schedules.
package des_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } tdes_state_t;

    localparam int DES_ROUNDS = 16;

    localparam logic [1:0] KEY1 = 2'd0;
    localparam logic [1:0] KEY2 = 2'd1;
    localparam logic [1:0] KEY3 = 2'd2;

    // Decrypt round 0 consumes the unrotated C0D0 (= K16), so its first entry is 0.
    localparam logic [1:0] DES_ENC_SHIFT [DES_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };
    localparam logic [1:0] DES_DEC_SHIFT [DES_ROUNDS] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Returns {pass_dec, key_sel} for a pass; EDE order reverses keys when decrypting.
    function automatic logic [2:0] pass_map(input logic [1:0] pass, input logic dec,
                                            input logic single);
        logic [1:0] key;
        logic       pdir;
        if (single) begin
            key  = KEY1;
            pdir = dec;
        end else if (dec) begin
            key  = (pass == 2'd0) ? KEY3 : (pass == 2'd1) ? KEY2 : KEY1;
            pdir = ~pass[0];
        end else begin
            key  = (pass == 2'd0) ? KEY1 : (pass == 2'd1) ? KEY2 : KEY3;
            pdir = pass[0];
        end
        return {pdir, key};
    endfunction

endpackage

// File: rtl/des_shift_table.sv
// Per-round C/D rotate amount lookup, selected by rotate direction.
module des_shift_table
    import des_pkg::*;
(
    input  logic [3:0] round_num_i,
    input  logic       dir_i,
    output logic [1:0] key_shift_o
);

    assign key_shift_o = dir_i ? DES_DEC_SHIFT[round_num_i] : DES_ENC_SHIFT[round_num_i];

endmodule

// File: rtl/tdes_round_ctrl.sv
// Triple-DES round sequencer: LOAD, 16 ROUNDs and FINAL per pass, then DONE until drained.
// Optional macro TDES_ABORT_EN adds an abort input that returns any busy block to IDLE.
module tdes_round_ctrl
    import des_pkg::*;
#(
    parameter int NUM_PASSES = 3
) (
    input  logic       clk,
    input  logic       n_rst,
`ifdef TDES_ABORT_EN
    input  logic       abort,
`endif
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_decrypt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       load_en,
    output logic       key_load,
    output logic [1:0] key_sel,
    output logic       pass_dec,
    output logic       round_en,
    output logic [3:0] round_num,
    output logic [1:0] key_shift,
    output logic       key_dir,
    output logic       final_en
);

    localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(DES_ROUNDS - 1);

    tdes_state_t state_q, state_d;
    logic [1:0]  pass_q, pass_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;
    logic        abort_w;
    logic [2:0]  map_d;
    logic [1:0]  shift_d;
    logic        busy_d;

`ifdef TDES_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        round_d = round_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                mode_d  = in_decrypt;
                pass_d  = 2'd0;
                round_d = 4'd0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                round_d = 4'd0;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (round_q == LAST_ROUND) state_d = ST_FINAL;
                else                       round_d = round_q + 4'd1;
            end
            ST_FINAL: begin
                if (pass_q != LAST_PASS) begin
                    pass_d  = pass_q + 2'd1;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (out_ready) begin
                pass_d  = 2'd0;
                round_d = 4'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_w && state_q != ST_IDLE) begin
            pass_d  = 2'd0;
            round_d = 4'd0;
            state_d = ST_IDLE;
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    assign map_d  = pass_map(pass_d, mode_d, NUM_PASSES == 1);
    assign busy_d = (state_d == ST_LOAD) || (state_d == ST_ROUND) || (state_d == ST_FINAL);

    des_shift_table u_shift (
        .round_num_i (round_d),
        .dir_i       (map_d[2]),
        .key_shift_o (shift_d)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q   <= ST_IDLE;
            pass_q    <= 2'd0;
            round_q   <= 4'd0;
            mode_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            load_en   <= 1'b0;
            key_load  <= 1'b0;
            key_sel   <= 2'd0;
            pass_dec  <= 1'b0;
            round_en  <= 1'b0;
            round_num <= 4'd0;
            key_shift <= 2'd0;
            key_dir   <= 1'b0;
            final_en  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            round_q   <= round_d;
            mode_q    <= mode_d;
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
            load_en   <= (state_d == ST_LOAD);
            key_load  <= (state_d == ST_LOAD);
            round_en  <= (state_d == ST_ROUND);
            final_en  <= (state_d == ST_FINAL);
            key_sel   <= busy_d ? map_d[1:0] : 2'd0;
            pass_dec  <= busy_d ? map_d[2] : 1'b0;
            key_dir   <= busy_d ? map_d[2] : 1'b0;
            round_num <= (state_d == ST_ROUND) ? round_d : 4'd0;
            key_shift <= (state_d == ST_ROUND) ? shift_d : 2'd0;
        end
    end

endmodule

// File: tb/tb_tdes_round_ctrl.sv
// Directed bench for tdes_round_ctrl: 3-pass and 1-pass instances, immediate-assertion checks.
module tb_tdes_round_ctrl;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic in_valid = 1'b0, in_decrypt = 1'b0, out_ready = 1'b0;
    logic in_valid1 = 1'b0, out_ready1 = 1'b0;
`ifdef TDES_ABORT_EN
    logic abort = 1'b0;
    logic abort1 = 1'b0;
`endif

    logic       in_ready, out_valid, load_en, key_load, pass_dec, round_en, key_dir, final_en;
    logic [1:0] key_sel, key_shift;
    logic [3:0] round_num;
    logic       in_ready1, out_valid1, load_en1, key_load1, pass_dec1, round_en1, key_dir1, final_en1;
    logic [1:0] key_sel1, key_shift1;
    logic [3:0] round_num1;

    int total = 0;
    int bad   = 0;

    logic [1:0] enc_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [1:0] dec_t [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [15:0] IDLE_V = 16'h8000;

    always #5 clk = ~clk;

    tdes_round_ctrl #(.NUM_PASSES(3)) dut3 (
        .clk(clk), .n_rst(n_rst),
`ifdef TDES_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .load_en(load_en),
        .key_load(key_load), .key_sel(key_sel), .pass_dec(pass_dec),
        .round_en(round_en), .round_num(round_num), .key_shift(key_shift),
        .key_dir(key_dir), .final_en(final_en)
    );

    tdes_round_ctrl #(.NUM_PASSES(1)) dut1 (
        .clk(clk), .n_rst(n_rst),
`ifdef TDES_ABORT_EN
        .abort(abort1),
`endif
        .in_valid(in_valid1), .in_ready(in_ready1), .in_decrypt(in_decrypt),
        .out_valid(out_valid1), .out_ready(out_ready1), .load_en(load_en1),
        .key_load(key_load1), .key_sel(key_sel1), .pass_dec(pass_dec1),
        .round_en(round_en1), .round_num(round_num1), .key_shift(key_shift1),
        .key_dir(key_dir1), .final_en(final_en1)
    );

    // {in_ready, out_valid, load_en, key_load, key_sel, pass_dec, round_en,
    //  round_num, key_shift, key_dir, final_en}
    logic [15:0] obs3, obs1;
    assign obs3 = {in_ready, out_valid, load_en, key_load, key_sel, pass_dec, round_en,
                   round_num, key_shift, key_dir, final_en};
    assign obs1 = {in_ready1, out_valid1, load_en1, key_load1, key_sel1, pass_dec1, round_en1,
                   round_num1, key_shift1, key_dir1, final_en1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs k edges after the accepting edge (k=0 is the LOAD of pass 0).
    function automatic logic [15:0] exp_vec(input int np, input bit dec, input int k,
                                            input int stall);
        logic       ir, ov, le, kl, pd, re, fe;
        logic [1:0] ks, sh;
        logic [3:0] rn;
        int         p, r;
        ir = 0; ov = 0; le = 0; kl = 0; pd = 0; re = 0; fe = 0;
        ks = 0; sh = 0; rn = 0;
        if (k < 18 * np) begin
            p = k / 18;
            r = k % 18;
            if (np == 1)  begin ks = 2'd0;        pd = dec;   end
            else if (dec) begin ks = 2'(2 - p);   pd = ~p[0]; end
            else          begin ks = 2'(p);       pd = p[0];  end
            if (r == 0) begin
                le = 1; kl = 1;
            end else if (r <= 16) begin
                re = 1;
                rn = 4'(r - 1);
                sh = pd ? dec_t[r-1] : enc_t[r-1];
            end else begin
                fe = 1;
            end
        end else if (k <= 18 * np + stall) begin
            ov = 1;
        end else begin
            ir = 1;
        end
        return {ir, ov, le, kl, ks, pd, re, rn, sh, pd, fe};
    endfunction

    task automatic run_block(input bit dec, input int stall);
        logic [15:0] e;
        int          sum;
        chk("accept_ready", 16'(in_ready), 16'd1);
        in_valid = 1; in_decrypt = dec;
        tick();
        in_valid = 0; in_decrypt = 0;
        sum = 0;
        for (int k = 0; k <= 55 + stall; k++) begin
            e = exp_vec(3, dec, k, stall);
            chk($sformatf("blk dec=%0d stall=%0d k=%0d", dec, stall, k), obs3, e);
            if (e[8]) sum += int'(key_shift);
            if (e[0]) begin
                chk($sformatf("shift_sum dec=%0d k=%0d", dec, k), 16'(sum), e[1] ? 16'd27 : 16'd28);
                sum = 0;
            end
            out_ready  = (k < 54) ? k[0] : (k >= 54 + stall);
            in_valid   = (stall > 0) && (k >= 54) && (k < 54 + stall);
            in_decrypt = ~dec;
            if (k < 55 + stall) tick();
        end
        in_valid = 0; in_decrypt = 0; out_ready = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held
        repeat (3) tick();
        chk("reset_hold3", obs3, IDLE_V);
        chk("reset_hold1", obs1, IDLE_V);
        n_rst = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_%0d", i), obs3, IDLE_V);
        end

        run_block(0, 0);
        run_block(1, 0);
        run_block(0, 5);
        run_block(1, 0);

        // asynchronous reset at pass 1 round 7
        in_valid = 1; in_decrypt = 0;
        tick();
        in_valid = 0;
        repeat (26) tick();
        chk("pre_rst_p1r7", obs3, exp_vec(3, 0, 26, 0));
        n_rst = 1;
        #1;
        chk("async_rst", obs3, IDLE_V);
        tick();
        n_rst = 0;
        tick();
        chk("after_rst_idle", obs3, IDLE_V);
        run_block(0, 0);

        // single-pass instance, decrypt then encrypt
        for (int m = 1; m >= 0; m--) begin
            chk("p1_ready", 16'(in_ready1), 16'd1);
            in_valid1 = 1; in_decrypt = m[0];
            tick();
            in_valid1 = 0; in_decrypt = 0;
            for (int k = 0; k <= 19; k++) begin
                chk($sformatf("p1 dec=%0d k=%0d", m, k), obs1, exp_vec(1, m[0], k, 0));
                out_ready1 = (k >= 18);
                if (k < 19) tick();
            end
            out_ready1 = 0;
        end

`ifdef TDES_ABORT_EN
        in_valid = 1; in_decrypt = 0;
        tick();
        in_valid = 0;
        repeat (40) tick();
        chk("pre_abort_p2r3", obs3, exp_vec(3, 0, 40, 0));
        abort = 1;
        tick();
        abort = 0;
        chk("abort_idle", obs3, IDLE_V);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort_stay_%0d", i), obs3, IDLE_V);
        end
        abort = 1;
        tick();
        abort = 0;
        chk("abort_in_idle", obs3, IDLE_V);
        run_block(1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
